// File: rtl/pci_target_mem.sv
// pci_target_mem: PCI-style burst target memory with byte enables, initial wait states and wrap or disconnect at the end of memory.
//   clk, rst_n                      clock, asynchronous active-low reset
//   frame_n, irdy_n, cbe_n, ad_in   initiator side: FRAME#, IRDY#, command/byte enables, address/write data
//   ad_out, ad_oe                   read data and its drive enable, resolved onto AD by the top level
//   devsel_n, trdy_n, stop_n        registered target handshake
//   done, beats                     end-of-burst pulse and transfer count of the last claimed burst
module pci_target_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int unsigned BASE_ADDR = 0,
  parameter int WAIT_STATES = 0,
  parameter bit WRAP = 1'b1,
  localparam int BE_W = DATA_W / 8,
  localparam int ADDR_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_n,
  input  logic              irdy_n,
  input  logic [BE_W-1:0]   cbe_n,
  input  logic [DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              devsel_n,
  output logic              trdy_n,
  output logic              stop_n,
  output logic              done,
  output logic [ADDR_W+7:0] beats
);
  localparam int UW = DATA_W - ADDR_W - 2;
  localparam logic [UW-1:0] BASE_HI = UW'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W+7:0] BMAX = '1;
  localparam logic [2:0] IDLE = 3'd0, WAIT = 3'd1, DATA = 3'd2, BACKOFF = 3'd3, IGNORE = 3'd4;
  logic [2:0] state;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] ptr, aptr, nxt;
  logic rd, is_rd, is_wr, hit, xfer, at_last;
  logic [DATA_W-1:0] mem [DEPTH];
  assign aptr = ad_in[ADDR_W+1:2];
  assign is_rd = cbe_n[3:0] == 4'b0110;
  assign is_wr = cbe_n[3:0] == 4'b0111;
  // word indices past DEPTH-1 (non power-of-2 depth) are not ours
  assign hit = (is_rd || is_wr) && ad_in[DATA_W-1:ADDR_W+2] == BASE_HI && 32'(aptr) < DEPTH;
  assign xfer = state == DATA && !irdy_n && !trdy_n;
  assign at_last = ptr == LAST;
  assign nxt = at_last ? '0 : ptr + 1'b1;
  assign ad_out = ad_oe ? mem[ptr] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      rd <= 1'b0;
      devsel_n <= 1'b1;
      trdy_n <= 1'b1;
      stop_n <= 1'b1;
      ad_oe <= 1'b0;
      done <= 1'b0;
      beats <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (!frame_n) begin
          if (hit) begin
            state <= WAIT;
            ptr <= aptr;
            rd <= is_rd;
            devsel_n <= 1'b0;
            beats <= '0;
            // reads spend one extra edge on the AD turnaround
            cnt <= 4'(WAIT_STATES) + {3'b0, is_rd};
          end else state <= IGNORE;
        end
        WAIT: begin
          ad_oe <= rd;
          if (cnt == 4'd0) begin
            state <= DATA;
            trdy_n <= 1'b0;
            stop_n <= WRAP || !at_last;
          end else cnt <= cnt - 1'b1;
        end
        DATA: if (xfer) begin
          if (!rd) for (int i = 0; i < BE_W; i++) if (!cbe_n[i]) mem[ptr][8*i +: 8] <= ad_in[8*i +: 8];
          beats <= beats == BMAX ? beats : beats + 1'b1;
          ptr <= nxt;
          if (frame_n) begin
            state <= IDLE;
            devsel_n <= 1'b1;
            trdy_n <= 1'b1;
            stop_n <= 1'b1;
            ad_oe <= 1'b0;
            done <= 1'b1;
          end else if (!WRAP && at_last) begin
            // disconnect-with-data already signalled; hold STOP# until FRAME# rises
            state <= BACKOFF;
            trdy_n <= 1'b1;
            ad_oe <= 1'b0;
          end else stop_n <= WRAP || nxt != LAST;
        end
        BACKOFF: if (frame_n) begin
          state <= IDLE;
          devsel_n <= 1'b1;
          stop_n <= 1'b1;
          done <= 1'b1;
        end
        IGNORE: if (frame_n && irdy_n) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
